// File: rtl/img_stream_ctrl.sv
// img_stream_ctrl: frame-level sequencer for the sliding-window line buffer.
// Walks the pixel memory, enables the line buffer in step with the 1-cycle
// memory read latency, honours downstream backpressure, tags every emitted
// window with row/col/border info and issues one trailing self-clear enable.
// Optional build macro IMG_STREAM_PERF_EN adds stall/frame cycle counters.
//
// Handshake: a window is transferred in a RUN cycle when out_ready_i=1
// ("fire"); buf_enable_o equals fire, and the window produced by that shift
// is flagged by win_valid_o one cycle later. With out_ready_i=0 nothing moves.
module img_stream_ctrl #(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned HEIGHT     = 256,
  parameter int unsigned FILT_WIDTH = 3,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              buf_enable_o,
  output logic              win_valid_o,
  output logic [15:0]       win_row_o,
  output logic [15:0]       win_col_o,
  output logic              win_border_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
`ifdef IMG_STREAM_PERF_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       frame_cycles_o
`endif
);

  localparam int unsigned HALF  = FILT_WIDTH / 2;
  localparam int unsigned LAT   = WIDTH * HALF + HALF;
  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned N_TOT = NPIX + LAT;

  localparam logic [15:0] HALF16  = 16'(HALF);
  localparam logic [15:0] COL_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_HI  = 16'(HEIGHT - HALF);
  localparam logic [15:0] COL_HI  = 16'(WIDTH - HALF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_CLEAR = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] in_cnt_q;
  logic [31:0] addr_nxt;
  logic [15:0] row_q, col_q;
  logic        fire;
  logic        start_acc;
  logic        border;
  logic        win_valid_q, win_border_q;
  logic [15:0] win_row_q, win_col_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, read address and line buffer enable.
  always_comb begin
    state_d      = state_q;
    fire         = 1'b0;
    start_acc    = 1'b0;
    buf_enable_o = 1'b0;
    rd_addr_o    = '0;
    addr_nxt     = in_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = S_PRIME;
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN: begin
        fire         = out_ready_i;
        buf_enable_o = fire;
        // Read one ahead on a fire so memory data lines up with the next shift.
        addr_nxt     = in_cnt_q + 32'(fire);
        rd_addr_o    = (addr_nxt >= NPIX - 1) ? ADDR_W'(NPIX - 1) : ADDR_W'(addr_nxt);
        if (fire && (in_cnt_q == N_TOT - 1)) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        buf_enable_o = 1'b1;
        state_d      = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign border = (row_q < HALF16) | (row_q >= ROW_HI) |
                  (col_q < HALF16) | (col_q >= COL_HI);

  // Input counter, raster position and registered window tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_border_q <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      if (start_acc) begin
        in_cnt_q <= '0;
        row_q    <= '0;
        col_q    <= '0;
      end else if (fire) begin
        in_cnt_q <= in_cnt_q + 32'd1;
      end
      // Windows only become valid once the buffer holds LAT pixels.
      if (fire && (in_cnt_q >= LAT)) begin
        win_valid_q  <= 1'b1;
        win_row_q    <= row_q;
        win_col_q    <= col_q;
        win_border_q <= border;
        if (col_q == COL_MAX) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

`ifdef IMG_STREAM_PERF_EN
  logic [31:0] stall_q, frame_q;

  // Performance counters; they freeze once the frame returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_q <= '0;
      frame_q <= '0;
    end else begin
      if ((state_q == S_RUN) && !out_ready_i) stall_q <= stall_q + 32'd1;
      if (state_q != S_IDLE)                  frame_q <= frame_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign frame_cycles_o = frame_q;
`endif

  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign win_border_o = win_border_q;
  assign busy_o       = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_CLEAR);
  assign done_o       = (state_q == S_FIN);
  assign state_o      = state_q;

endmodule

// File: tb/tb_img_stream_ctrl.sv
// Directed bench for img_stream_ctrl on a 4x4 image with a 3x3 filter.
// LAT = 5, N_TOT = 21: 21 RUN enables, windows tagged from the 6th enable on.
module tb_img_stream_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int RUN_EN = 21;   // WIDTH*HEIGHT + WIDTH*1 + 1
  localparam int FIRST_TAG = 5; // 0-based index of the first tagged enable

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        out_ready_i = 1'b1;
  logic [15:0] rd_addr_o;
  logic        buf_enable_o, win_valid_o, win_border_o, busy_o, done_o;
  logic [15:0] win_row_o, win_col_o;
  logic [2:0]  state_o;
`ifdef IMG_STREAM_PERF_EN
  logic [31:0] stall_cycles_o, frame_cycles_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];   // {row, col, border}
  bit pat_tbl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  img_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .FILT_WIDTH(3), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .out_ready_i(out_ready_i),
    .rd_addr_o(rd_addr_o), .buf_enable_o(buf_enable_o), .win_valid_o(win_valid_o),
    .win_row_o(win_row_o), .win_col_o(win_col_o), .win_border_o(win_border_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
`ifdef IMG_STREAM_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .frame_cycles_o(frame_cycles_o)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({16'(r), 16'(c), (r == 0 || r == H-1 || c == 0 || c == W-1)});
  endtask

  task automatic check_win();
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      chk("win_extra", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("win_row", win_row_o, 32'(e[32:17]));
      chk("win_col", win_col_o, 32'(e[16:1]));
      chk("win_border", win_border_o, 32'(e[0]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_addr"}, rd_addr_o, 0);
    chk({tag, "_en"}, buf_enable_o, 0);
    chk({tag, "_wv"}, win_valid_o, 0);
    chk({tag, "_row"}, win_row_o, 0);
    chk({tag, "_col"}, win_col_o, 0);
    chk({tag, "_border"}, win_border_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // One frame. pat 0: always ready, pat 1: ready 1,0,0,1 repeating.
  // abort_win > 0 asserts rst right after that many windows were seen.
  task automatic run_frame(input int pat, input int abort_win,
                           input bit start_in_run, input bit start_in_fin);
    int n_en, n_win, run_cyc, n_stall, exp_addr;
    bit prev_tag, rdy;
    fill_exp();
    out_ready_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; #1;
    chk("prime_state", state_o, 1);
    chk("prime_busy", busy_o, 1);
    chk("prime_addr", rd_addr_o, 0);
    chk("prime_en", buf_enable_o, 0);
    @(posedge clk); #1;
    n_en = 0; n_win = 0; run_cyc = 0; n_stall = 0; prev_tag = 1'b0;
    while (n_en < RUN_EN && run_cyc < 200) begin
      rdy = (pat == 0) ? 1'b1 : pat_tbl[run_cyc % 4];
      out_ready_i = rdy;
      start_i = start_in_run && (run_cyc == 3);
      #1;
      exp_addr = n_en + int'(rdy);
      if (exp_addr > W*H - 1) exp_addr = W*H - 1;
      chk("run_state", state_o, 2);
      chk("run_en", buf_enable_o, 32'(rdy));
      chk("run_addr", rd_addr_o, 32'(exp_addr));
      chk("run_wv", win_valid_o, 32'(prev_tag));
      if (win_valid_o) begin
        check_win();
        n_win++;
      end
      if (abort_win > 0 && n_win == abort_win) begin
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        return;
      end
      prev_tag = rdy && (n_en >= FIRST_TAG);
      if (!rdy) n_stall++;
      if (rdy) n_en++;
      run_cyc++;
      @(posedge clk); #1;
    end
    if (run_cyc >= 200) chk("run_timeout", 1, 0);
    // CLEAR: enable regardless of out_ready; carries the last window tag.
    out_ready_i = 1'b0;
    start_i = 1'b0; #1;
    chk("clear_state", state_o, 3);
    chk("clear_en", buf_enable_o, 1);
    chk("clear_busy", busy_o, 1);
    chk("clear_wv", win_valid_o, 32'(prev_tag));
    if (win_valid_o) begin
      check_win();
      n_win++;
    end
    @(posedge clk); #1;
    start_i = start_in_fin; #1;
    chk("fin_state", state_o, 4);
    chk("fin_done", done_o, 1);
    chk("fin_busy", busy_o, 0);
    chk("fin_wv", win_valid_o, 0);
    chk("fin_en", buf_enable_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0; #1;
    chk("idle_state", state_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_busy", busy_o, 0);
    @(posedge clk); #1;
    chk("idle2_state", state_o, 0);
    chk("n_win", n_win, 16);
    chk("exp_left", exp_q.size(), 0);
`ifdef IMG_STREAM_PERF_EN
    chk("stall_cycles", stall_cycles_o, 32'(n_stall));
    chk("frame_cycles", frame_cycles_o, 32'(run_cyc + 3));
`endif
    out_ready_i = 1'b1;
  endtask

  initial begin
    // Reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; #1;
    check_all_zero("reset");
    @(posedge clk); #1;

    run_frame(0, 0, 1'b0, 1'b0);  // full-rate frame
    run_frame(1, 0, 1'b0, 1'b0);  // backpressure toggling
    run_frame(0, 7, 1'b0, 1'b0);  // reset at window 7
    @(posedge clk); #1;
    run_frame(0, 0, 1'b0, 1'b0);  // fresh frame after reset
    run_frame(1, 0, 1'b1, 1'b1);  // start pulses in RUN and FIN ignored
    run_frame(0, 0, 1'b0, 1'b0);  // next frame needs start in IDLE

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
